demux2x4_pair: RTL and testbench

- Downstream neighbour of the 4-to-2 lane mux in the PCIe physical-layer datapath.
- Takes the two narrow mux output lanes and regroups each lane's consecutive words into pairs, restoring the four-lane view.
  - Lane A feeds outputs 0/1.
  - Lane B feeds outputs 2/3.
- A per-lane idle timeout flushes an unpaired word, so a trailing odd word is never stranded.

---
 rtl/demux2x4_pair.sv | 124 ++++++++++++
 tb/tb_demux2x4_pair.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/demux2x4_pair.sv
// Regroups two narrow lanes of consecutive words back into a four-lane view:
// lane A pairs onto out0/out1, lane B onto out2/out3, with an idle-timeout flush.
module demux2x4_pair #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [1:0]        valid_in,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [3:0]        valid_out,
  output logic [1:0]        pending,
  output logic [1:0]        flush_evt
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  // Idle count at which a lone word is flushed; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0][DATA_W-1:0] data_in;

  state_e                 state_q    [2];
  state_e                 state_d    [2];
  logic [1:0][DATA_W-1:0] hold_q,     hold_d;
  logic [1:0][CNT_W-1:0]  cnt_q,      cnt_d;
  logic [1:0][DATA_W-1:0] even_q,     even_d;
  logic [1:0][DATA_W-1:0] odd_q,      odd_d;
  logic [1:0]             vld_even_q, vld_even_d;
  logic [1:0]             vld_odd_q,  vld_odd_d;
  logic [1:0]             flush_q,    flush_d;
  logic [1:0]             pending_q,  pending_d;

  assign data_in = {in1, in0};

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      state_d[l]    = state_q[l];
      hold_d[l]     = hold_q[l];
      cnt_d[l]      = cnt_q[l];
      even_d[l]     = even_q[l];
      odd_d[l]      = odd_q[l];
      vld_even_d[l] = 1'b0;
      vld_odd_d[l]  = 1'b0;
      flush_d[l]    = 1'b0;

      if (state_q[l] == EMPTY) begin
        if (valid_in[l]) begin
          hold_d[l]  = data_in[l];
          cnt_d[l]   = '0;
          state_d[l] = HALF;
        end
      end else begin
        // A second word wins over a timeout expiring in the same cycle.
        if (valid_in[l]) begin
          even_d[l]     = hold_q[l];
          odd_d[l]      = data_in[l];
          vld_even_d[l] = 1'b1;
          vld_odd_d[l]  = 1'b1;
          state_d[l]    = EMPTY;
        end else if ((TIMEOUT != 0) && (cnt_q[l] == CNT_LAST)) begin
          even_d[l]     = hold_q[l];
          vld_even_d[l] = 1'b1;
          flush_d[l]    = 1'b1;
          state_d[l]    = EMPTY;
        end else if (cnt_q[l] != CNT_MAX) begin
          cnt_d[l] = cnt_q[l] + 1'b1;
        end
      end

      pending_d[l] = (state_d[l] == HALF);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: held words are cleared too, so a word caught mid-pair by reset can never leak out.
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= EMPTY;
      end
      hold_q     <= '0;
      cnt_q      <= '0;
      even_q     <= '0;
      odd_q      <= '0;
      vld_even_q <= '0;
      vld_odd_q  <= '0;
      flush_q    <= '0;
      pending_q  <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        state_q[l] <= state_d[l];
      end
      hold_q     <= hold_d;
      cnt_q      <= cnt_d;
      even_q     <= even_d;
      odd_q      <= odd_d;
      vld_even_q <= vld_even_d;
      vld_odd_q  <= vld_odd_d;
      flush_q    <= flush_d;
      pending_q  <= pending_d;
    end
  end

  assign out0      = even_q[0];
  assign out1      = odd_q[0];
  assign out2      = even_q[1];
  assign out3      = odd_q[1];
  assign valid_out = {vld_odd_q[1], vld_even_q[1], vld_odd_q[0], vld_even_q[0]};
  assign pending   = pending_q;
  assign flush_evt = flush_q;

endmodule

// File: tb/tb_demux2x4_pair.sv
// Directed bench for demux2x4_pair: reset, pairing, timeout flush, timeout race,
// dual-lane streaming and reset mid-pair, each with hand-computed expectations.
module tb_demux2x4_pair;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in0, in1;
  logic [1:0]        valid_in;
  logic [DATA_W-1:0] out0, out1, out2, out3;
  logic [3:0]        valid_out;
  logic [1:0]        pending;
  logic [1:0]        flush_evt;

  int checks = 0;
  int errors = 0;

  demux2x4_pair #(.DATA_W(DATA_W), .TIMEOUT(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .valid_in  (valid_in),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .valid_out (valid_out),
    .pending   (pending),
    .flush_evt (flush_evt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 2'b11;
    in0      = 8'($urandom);
    in1      = 8'($urandom);

    // Reset held low three cycles with both lanes active.
    for (int i = 0; i < 3; i++) begin
      tick();
      in0 = 8'($urandom);
      in1 = 8'($urandom);
    end
    check("rst_out0", 32'(out0), 32'h0);
    check("rst_out1", 32'(out1), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);
    check("rst_out3", 32'(out3), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_flush", 32'(flush_evt), 32'h0);

    reset    = 1'b1;
    valid_in = 2'b00;
    tick();
    check("idle1_valid", 32'(valid_out), 32'h0);
    tick();
    check("idle2_valid", 32'(valid_out), 32'h0);
    check("idle2_pending", 32'(pending), 32'h0);

    // Lane A pair 0xA1, 0xA2.
    in0 = 8'hA1; valid_in = 2'b01;
    tick();
    check("a_half_pending", 32'(pending), 32'h1);
    check("a_half_valid", 32'(valid_out), 32'h0);
    in0 = 8'hA2;
    tick();
    check("a_pair_out0", 32'(out0), 32'hA1);
    check("a_pair_out1", 32'(out1), 32'hA2);
    check("a_pair_valid", 32'(valid_out), 32'h3);
    check("a_pair_pending", 32'(pending), 32'h0);
    valid_in = 2'b00;
    tick();
    check("a_pair_pulse", 32'(valid_out), 32'h0);
    check("a_hold_out0", 32'(out0), 32'hA1);

    // Lane B pair first so out3 holds a known non-zero value.
    in1 = 8'h31; valid_in = 2'b10;
    tick();
    in1 = 8'h32;
    tick();
    check("b_pair_out2", 32'(out2), 32'h31);
    check("b_pair_out3", 32'(out3), 32'h32);
    check("b_pair_valid", 32'(valid_out), 32'hC);

    // Lone 0xB7 on lane B flushes four cycles after it is sampled.
    in1 = 8'hB7;
    tick();
    valid_in = 2'b00;
    tick();
    check("b_wait1_valid", 32'(valid_out), 32'h0);
    check("b_wait1_pending", 32'(pending), 32'h2);
    tick();
    tick();
    check("b_wait3_valid", 32'(valid_out), 32'h0);
    check("b_wait3_flush", 32'(flush_evt), 32'h0);
    tick();
    check("b_flush_out2", 32'(out2), 32'hB7);
    check("b_flush_out3", 32'(out3), 32'h32);
    check("b_flush_valid", 32'(valid_out), 32'h4);
    check("b_flush_evt", 32'(flush_evt), 32'h2);
    check("b_flush_pending", 32'(pending), 32'h0);
    tick();
    check("b_flush_pulse", 32'(flush_evt), 32'h0);
    check("b_flush_vpulse", 32'(valid_out), 32'h0);

    // Second word arrives on the exact cycle the timeout would fire.
    in0 = 8'h11; valid_in = 2'b01;
    tick();
    valid_in = 2'b00;
    tick();
    tick();
    tick();
    check("race_pending", 32'(pending), 32'h1);
    in0 = 8'h22; valid_in = 2'b01;
    tick();
    check("race_out0", 32'(out0), 32'h11);
    check("race_out1", 32'(out1), 32'h22);
    check("race_valid", 32'(valid_out), 32'h3);
    check("race_flush", 32'(flush_evt), 32'h0);
    valid_in = 2'b00;
    tick();
    check("race_after_valid", 32'(valid_out), 32'h0);

    // Both lanes streaming back-to-back.
    for (int k = 0; k < 8; k++) begin
      in0      = 8'(k);
      in1      = 8'(8'h80 + k);
      valid_in = 2'b11;
      tick();
      if (k % 2 == 1) begin
        check("str_out0", 32'(out0), 32'(k - 1));
        check("str_out1", 32'(out1), 32'(k));
        check("str_out2", 32'(out2), 32'(8'h80 + k - 1));
        check("str_out3", 32'(out3), 32'(8'h80 + k));
        check("str_valid", 32'(valid_out), 32'hF);
      end else begin
        check("str_gap_valid", 32'(valid_out), 32'h0);
      end
      check("str_flush", 32'(flush_evt), 32'h0);
    end
    valid_in = 2'b00;
    tick();
    check("str_end_valid", 32'(valid_out), 32'h0);
    check("str_end_pending", 32'(pending), 32'h0);

    // Reset while lane A holds 0x5C; the held word must vanish.
    in0 = 8'h5C; valid_in = 2'b01;
    tick();
    check("mid_pending", 32'(pending), 32'h1);
    reset = 1'b0; valid_in = 2'b00;
    tick();
    check("mid_rst_pending", 32'(pending), 32'h0);
    check("mid_rst_valid", 32'(valid_out), 32'h0);
    reset = 1'b1;
    in0 = 8'h61; valid_in = 2'b01;
    tick();
    in0 = 8'h62;
    tick();
    check("post_out0", 32'(out0), 32'h61);
    check("post_out1", 32'(out1), 32'h62);
    check("post_valid", 32'(valid_out), 32'h3);
    valid_in = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_idle_valid", 32'(valid_out), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
